// File: rtl/cmp_hysteresis_detector.sv
// Debounced, hysteretic threshold alarm driven by per-sample eq/gt/lt comparator flags.
// Also produces edge pulses, a saturating rise counter and a sticky illegal-flag error.
module cmp_hysteresis_detector #(
  parameter int unsigned RISE_COUNT = 4,
  parameter int unsigned FALL_COUNT = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic             eq,
  input  logic             gt,
  input  logic             lt,
  output logic             alarm,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] run_cnt,
  output logic [CNT_W-1:0] rise_events,
  output logic             err
);

  typedef enum logic [1:0] {
    S_LOW    = 2'd0,
    S_ARM    = 2'd1,
    S_HIGH   = 2'd2,
    S_DISARM = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] RISE_C = CNT_W'(RISE_COUNT);
  localparam logic [CNT_W-1:0] FALL_C = CNT_W'(FALL_COUNT);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  state_t           state;
  logic             one_hot_c;
  logic [CNT_W-1:0] run_nxt_c;
  logic [CNT_W-1:0] ev_sat_c;

  assign one_hot_c = ({eq, gt, lt} == 3'b001) || ({eq, gt, lt} == 3'b010) ||
                     ({eq, gt, lt} == 3'b100);
  assign run_nxt_c = run_cnt + ONE_C;
  assign ev_sat_c  = (rise_events == '1) ? rise_events : rise_events + ONE_C;

  // eq samples are legal but neither advance nor break a run, so only gt/lt reach the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_LOW;
      run_cnt     <= '0;
      rise_events <= '0;
      err         <= 1'b0;
      alarm       <= 1'b0;
      rise_pulse  <= 1'b0;
      fall_pulse  <= 1'b0;
    end else if (clear) begin
      state       <= S_LOW;
      run_cnt     <= '0;
      rise_events <= '0;
      err         <= 1'b0;
      alarm       <= 1'b0;
      rise_pulse  <= 1'b0;
      fall_pulse  <= 1'b0;
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      if (in_valid && !one_hot_c) begin
        err <= 1'b1;
      end else if (in_valid && (gt || lt)) begin
        case (state)
          S_LOW: begin
            if (gt) begin
              if (RISE_COUNT == 1) begin
                state       <= S_HIGH;
                run_cnt     <= '0;
                alarm       <= 1'b1;
                rise_pulse  <= 1'b1;
                rise_events <= ev_sat_c;
              end else begin
                state   <= S_ARM;
                run_cnt <= ONE_C;
              end
            end
          end
          S_ARM: begin
            if (gt) begin
              if (run_nxt_c == RISE_C) begin
                state       <= S_HIGH;
                run_cnt     <= '0;
                alarm       <= 1'b1;
                rise_pulse  <= 1'b1;
                rise_events <= ev_sat_c;
              end else begin
                run_cnt <= run_nxt_c;
              end
            end else begin
              state   <= S_LOW;
              run_cnt <= '0;
            end
          end
          S_HIGH: begin
            if (lt) begin
              if (FALL_COUNT == 1) begin
                state      <= S_LOW;
                run_cnt    <= '0;
                alarm      <= 1'b0;
                fall_pulse <= 1'b1;
              end else begin
                state   <= S_DISARM;
                run_cnt <= ONE_C;
              end
            end
          end
          S_DISARM: begin
            if (lt) begin
              if (run_nxt_c == FALL_C) begin
                state      <= S_LOW;
                run_cnt    <= '0;
                alarm      <= 1'b0;
                fall_pulse <= 1'b1;
              end else begin
                run_cnt <= run_nxt_c;
              end
            end else begin
              state   <= S_HIGH;
              run_cnt <= '0;
            end
          end
          default: begin
            state   <= S_LOW;
            run_cnt <= '0;
            alarm   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmp_hysteresis_detector.sv
// Directed bench: instance a (RISE=3, FALL=2) and instance b (RISE=1, FALL=1, CNT_W=2).
module tb_cmp_hysteresis_detector;

  logic       clk = 1'b0;
  logic       rst_n_a, clear_a, valid_a, eq_a, gt_a, lt_a;
  logic       alarm_a, rp_a, fp_a, err_a;
  logic [7:0] run_a, ev_a;
  logic       rst_n_b, clear_b, valid_b, eq_b, gt_b, lt_b;
  logic       alarm_b, rp_b, fp_b, err_b;
  logic [1:0] run_b, ev_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cmp_hysteresis_detector #(.RISE_COUNT(3), .FALL_COUNT(2), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .clear(clear_a), .in_valid(valid_a),
    .eq(eq_a), .gt(gt_a), .lt(lt_a),
    .alarm(alarm_a), .rise_pulse(rp_a), .fall_pulse(fp_a),
    .run_cnt(run_a), .rise_events(ev_a), .err(err_a)
  );

  cmp_hysteresis_detector #(.RISE_COUNT(1), .FALL_COUNT(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .clear(clear_b), .in_valid(valid_b),
    .eq(eq_b), .gt(gt_b), .lt(lt_b),
    .alarm(alarm_b), .rise_pulse(rp_b), .fall_pulse(fp_b),
    .run_cnt(run_b), .rise_events(ev_b), .err(err_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chka(input string tag, input logic al, input logic rp, input logic fp,
                      input logic [7:0] run, input logic [7:0] ev, input logic er);
    chk({tag, ".alarm"}, 32'(alarm_a), 32'(al));
    chk({tag, ".rise_pulse"}, 32'(rp_a), 32'(rp));
    chk({tag, ".fall_pulse"}, 32'(fp_a), 32'(fp));
    chk({tag, ".run_cnt"}, 32'(run_a), 32'(run));
    chk({tag, ".rise_events"}, 32'(ev_a), 32'(ev));
    chk({tag, ".err"}, 32'(err_a), 32'(er));
  endtask

  task automatic chkb(input string tag, input logic al, input logic rp, input logic fp,
                      input logic [1:0] ev);
    chk({tag, ".alarm"}, 32'(alarm_b), 32'(al));
    chk({tag, ".rise_pulse"}, 32'(rp_b), 32'(rp));
    chk({tag, ".fall_pulse"}, 32'(fp_b), 32'(fp));
    chk({tag, ".run_cnt"}, 32'(run_b), 32'(0));
    chk({tag, ".rise_events"}, 32'(ev_b), 32'(ev));
    chk({tag, ".err"}, 32'(err_b), 32'(0));
  endtask

  // Drive one cycle on instance a (flags as {eq,gt,lt}), then sample just after the edge.
  task automatic stepa(input logic v, input logic [2:0] f, input logic c);
    valid_a = v; {eq_a, gt_a, lt_a} = f; clear_a = c;
    @(posedge clk); #1;
    valid_a = 1'b0; {eq_a, gt_a, lt_a} = 3'b000; clear_a = 1'b0;
  endtask

  task automatic stepb(input logic v, input logic [2:0] f);
    valid_b = v; {eq_b, gt_b, lt_b} = f;
    @(posedge clk); #1;
    valid_b = 1'b0; {eq_b, gt_b, lt_b} = 3'b000;
  endtask

  localparam logic [2:0] EQ = 3'b100;
  localparam logic [2:0] GT = 3'b010;
  localparam logic [2:0] LT = 3'b001;

  initial begin
    rst_n_a = 1'b0; clear_a = 1'b0; valid_a = 1'b0; eq_a = 1'b0; gt_a = 1'b0; lt_a = 1'b0;
    rst_n_b = 1'b0; clear_b = 1'b0; valid_b = 1'b0; eq_b = 1'b0; gt_b = 1'b0; lt_b = 1'b0;
    #12;
    chka("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk); rst_n_a = 1'b1;
    stepa(0, GT, 0);
    chka("idle_after_reset", 0, 0, 0, 0, 0, 0);

    // Rise after three consecutive gt
    stepa(1, GT, 0); chka("t1_gt1", 0, 0, 0, 1, 0, 0);
    stepa(1, GT, 0); chka("t1_gt2", 0, 0, 0, 2, 0, 0);
    stepa(1, GT, 0); chka("t1_gt3", 1, 1, 0, 0, 1, 0);
    stepa(0, 3'b000, 0); chka("t1_pulse_end", 1, 0, 0, 0, 1, 0);

    // Fall interrupted by eq and an idle cycle
    stepa(1, LT, 0); chka("t3_lt1", 1, 0, 0, 1, 1, 0);
    stepa(1, EQ, 0); chka("t3_eq", 1, 0, 0, 1, 1, 0);
    stepa(0, LT, 0); chka("t3_idle", 1, 0, 0, 1, 1, 0);
    stepa(1, LT, 0); chka("t3_lt2", 0, 0, 1, 0, 1, 0);
    stepa(0, 3'b000, 0); chka("t3_pulse_end", 0, 0, 0, 0, 1, 0);

    // lt breaks the rise run
    stepa(1, GT, 0); chka("t2_gt1", 0, 0, 0, 1, 1, 0);
    stepa(1, GT, 0); chka("t2_gt2", 0, 0, 0, 2, 1, 0);
    stepa(1, LT, 0); chka("t2_lt", 0, 0, 0, 0, 1, 0);
    stepa(1, GT, 0); chka("t2_gt3", 0, 0, 0, 1, 1, 0);
    stepa(1, GT, 0); chka("t2_gt4", 0, 0, 0, 2, 1, 0);
    stepa(1, GT, 0); chka("t2_gt5", 1, 1, 0, 0, 2, 0);

    // gt in DISARM returns to HIGH without a pulse
    stepa(1, LT, 0); chka("t4_lt1", 1, 0, 0, 1, 2, 0);
    stepa(1, GT, 0); chka("t4_gt", 1, 0, 0, 0, 2, 0);
    stepa(1, LT, 0); chka("t4_lt2", 1, 0, 0, 1, 2, 0);

    // Illegal flags: err sticks, state/run hold (DISARM run 1)
    stepa(1, 3'b011, 0); chka("t5_gt_lt", 1, 0, 0, 1, 2, 1);
    stepa(1, 3'b000, 0); chka("t5_zero", 1, 0, 0, 1, 2, 1);
    stepa(1, LT, 0); chka("t5_lt_held", 0, 0, 1, 0, 2, 1);
    stepa(1, GT, 0); chka("t5_gt_arm", 0, 0, 0, 1, 2, 1);
    stepa(1, GT, 1); chka("t5_clear", 0, 0, 0, 0, 0, 0);
    stepa(1, GT, 0); chka("t5_after_clear", 0, 0, 0, 1, 0, 0);

    // Instance b: single-sample thresholds, saturating event counter
    @(negedge clk); rst_n_b = 1'b1;
    stepb(0, 3'b000);
    chkb("b_reset", 0, 0, 0, 0);
    stepb(1, GT); chkb("b_s1", 1, 1, 0, 1);
    stepb(1, LT); chkb("b_s2", 0, 0, 1, 1);
    stepb(1, GT); chkb("b_s3", 1, 1, 0, 2);
    stepb(1, LT); chkb("b_s4", 0, 0, 1, 2);
    stepb(1, GT); chkb("b_s5", 1, 1, 0, 3);
    stepb(1, LT); chkb("b_s6", 0, 0, 1, 3);
    stepb(1, GT); chkb("b_s7", 1, 1, 0, 3);
    stepb(1, LT); chkb("b_s8", 0, 0, 1, 3);
    stepb(1, GT); chkb("b_s9", 1, 1, 0, 3);
    stepb(1, LT); chkb("b_s10", 0, 0, 1, 3);
    stepb(1, GT); chkb("b_s11", 1, 1, 0, 3);

    // Asynchronous reset between edges clears outputs immediately
    #2 rst_n_b = 1'b0;
    #1 chkb("b_async_rst", 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmp_hysteresis_detector.md
Name: cmp_hysteresis_detector

Overview:
- Consumes the per-sample eq/gt/lt flags of the 8-bit magnitude comparator (a = live sample, b = threshold) and turns them into a debounced, hysteretic threshold alarm.
- Asserts the alarm after RISE_COUNT consecutive "greater" samples and releases it after FALL_COUNT consecutive "less" samples.
- Also produces single-cycle edge pulses, a saturating rise-event counter and a sticky flag for illegal flag combinations.
- Sits directly downstream of the comparator, in the same clock domain.

Parameters:
- RISE_COUNT, 4: consecutive gt samples required to enter alarm. Range 1 to 2^CNT_W-1.
- FALL_COUNT, 4: consecutive lt samples required to leave alarm. Range 1 to 2^CNT_W-1.
- CNT_W, 8: width of the run counter and the event counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous clear; returns the block to its reset state on the next edge
- in_valid  in  1  eq/gt/lt qualify this cycle
- eq  in  1  comparator equal flag
- gt  in  1  comparator greater flag
- lt  in  1  comparator less flag
- alarm  out  1  debounced level; high in states HIGH and DISARM
- rise_pulse  out  1  one-cycle pulse on the LOW/ARM-to-HIGH transition
- fall_pulse  out  1  one-cycle pulse on the DISARM-to-LOW transition
- run_cnt  out  CNT_W  current consecutive-qualifying-sample count
- rise_events  out  CNT_W  number of rise transitions, saturates at all-ones
- err  out  1  sticky; set by an illegal flag combination

Behaviour:
- Reset (rst_n low, async) and clear (sync): state=LOW; run_cnt=0; rise_events=0; err=0; alarm=0; rise_pulse=0; fall_pulse=0.
- clear has priority over in_valid in the same cycle; that cycle's sample is discarded.
- A sample is accepted on a rising edge with in_valid=1 and exactly one of eq/gt/lt high. in_valid=0 leaves all state unchanged and pulses low.
- Illegal sample (in_valid=1 and not one-hot, including all-zero): err is set on that edge, the sample is ignored, state and counters hold. err stays set until clear or reset.
- All outputs are registered. The effect of a sample accepted at edge k is visible after edge k. Pulses are high for exactly the cycle following edge k.
- FSM states: LOW, ARM, HIGH, DISARM. In every state, eq holds state and run_cnt (neither advances nor breaks a run).
- LOW:
  - gt: if RISE_COUNT==1, go to HIGH with run_cnt=0 and a rise pulse. Else go to ARM with run_cnt=1.
  - lt: stay.
- ARM:
  - gt: if run_cnt+1==RISE_COUNT, go to HIGH with run_cnt=0 and a rise pulse. Else run_cnt+1.
  - lt: go to LOW with run_cnt=0.
- HIGH:
  - lt: if FALL_COUNT==1, go to LOW with run_cnt=0 and a fall pulse. Else go to DISARM with run_cnt=1.
  - gt: stay.
- DISARM:
  - lt: if run_cnt+1==FALL_COUNT, go to LOW with run_cnt=0 and a fall pulse. Else run_cnt+1.
  - gt: go to HIGH with run_cnt=0 and no pulse.
- rise_events increments with every rise_pulse and never wraps.
- run_cnt never exceeds max(RISE_COUNT, FALL_COUNT)-1.
- Async reset mid-run discards the partial count. No pulse is produced on reset or clear.

Test Plan:
1. RISE=3, FALL=2; reset then gt,gt,gt valid on consecutive cycles -> run_cnt 1,2,0; alarm rises after the 3rd edge; rise_pulse high exactly 1 cycle; rise_events=1.
2. From LOW: gt,gt,lt,gt,gt,gt -> no alarm after the lt (run_cnt=0); alarm only after the final gt.
3. From HIGH: lt,eq,in_valid=0,lt -> alarm stays 1 through the eq and the idle cycle; fall_pulse after the 2nd lt; alarm=0.
4. From HIGH: lt,gt,lt -> after the gt, state HIGH with run_cnt=0 and no fall_pulse; the later lt gives run_cnt=1.
5. in_valid=1 with gt=lt=1, then in_valid=1 with all flags 0 -> err=1, state and run_cnt unchanged. clear asserted together with a valid gt -> err=0, run_cnt=0, gt ignored.
6. RISE=1, FALL=1, CNT_W=2; alternate gt/lt for 10 samples -> rise_pulse/fall_pulse every accepted sample; rise_events saturates at 3. Assert rst_n mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
